// File: rtl/sdram_refresh_arbiter_if.sv
// Handshake and status bundle between the Z2 bus tracker, the refresh
// arbiter and the SDRAM command sequencer.
interface sdram_refresh_arbiter_if;
    logic       init_done;
    logic       host_req;
    logic       host_done;
    logic       host_gnt;
    logic       ref_start;
    logic       ref_active;
    logic [3:0] pending;
    logic       ref_overflow;

    modport master (
        output init_done, host_req, host_done,
        input  host_gnt, ref_start, ref_active, pending, ref_overflow
    );

    modport slave (
        input  init_done, host_req, host_done,
        output host_gnt, ref_start, ref_active, pending, ref_overflow
    );
endinterface

// File: rtl/sdram_refresh_arbiter.sv
// Arbitrates the single SDRAM between Zorro II host cycles and auto-refresh,
// accruing refresh debt from an interval timer and forcing it out when full.
module sdram_refresh_arbiter #(
    parameter int unsigned REFRESH_INTERVAL = 390,
    parameter int unsigned MAX_PENDING      = 8,
    parameter int unsigned REF_CYCLES       = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    sdram_refresh_arbiter_if.slave  arb
);

    localparam int unsigned TIMER_W = $clog2(REFRESH_INTERVAL);
    localparam int unsigned RFC_W   = $clog2(REF_CYCLES + 1);
    localparam int unsigned PEND_W  = 4;

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(REFRESH_INTERVAL - 1);
    localparam logic [RFC_W-1:0]   RFC_LAST   = RFC_W'(REF_CYCLES - 1);
    localparam logic [PEND_W-1:0]  PEND_MAX   = PEND_W'(MAX_PENDING);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_HOST     = 2'd1,
        ST_HOST_END = 2'd2,
        ST_REFRESH  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q;
    logic [RFC_W-1:0]     rfc_q, rfc_d;
    logic [PEND_W-1:0]    pending_q;
    logic                 overflow_q;
    logic                 gnt_q;
    logic                 start_q, start_d;
    logic                 active_q;
    logic                 tick_c;
    logic                 pend_full_c;

    assign tick_c      = arb.init_done && (timer_q == TIMER_LAST);
    assign pend_full_c = (pending_q == PEND_MAX);

    // Free-running refresh interval timer, parked at zero until init completes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_q <= '0;
        end else if (!arb.init_done || tick_c) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_q + TIMER_W'(1);
        end
    end

    // Refresh debt: a tick and an issued refresh in the same clock cancel out
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else if (!arb.init_done) begin
            pending_q  <= '0;
        end else if (tick_c && !start_q) begin
            if (pend_full_c) begin
                overflow_q <= 1'b1;
            end else begin
                pending_q  <= pending_q + PEND_W'(1);
            end
        end else if (!tick_c && start_q && (pending_q != '0)) begin
            pending_q <= pending_q - PEND_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            rfc_q   <= '0;
        end else begin
            state_q <= state_d;
            rfc_q   <= rfc_d;
        end
    end

    // Next-state: urgent debt beats a new host request, but never a granted one
    always_comb begin
        state_d = state_q;
        rfc_d   = rfc_q;
        start_d = 1'b0;
        if (!arb.init_done) begin
            state_d = ST_IDLE;
            rfc_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    rfc_d = '0;
                    if (pend_full_c) begin
                        state_d = ST_REFRESH;
                        start_d = 1'b1;
                    end else if (arb.host_req) begin
                        state_d = ST_HOST;
                    end else if (pending_q != '0) begin
                        state_d = ST_REFRESH;
                        start_d = 1'b1;
                    end
                end
                ST_HOST: begin
                    if (arb.host_done) begin
                        state_d = ST_HOST_END;
                    end else if (!arb.host_req) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_HOST_END: begin
                    if (!arb.host_req) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_REFRESH: begin
                    if (rfc_q == RFC_LAST) begin
                        state_d = ST_IDLE;
                        rfc_d   = '0;
                    end else begin
                        rfc_d   = rfc_q + RFC_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    rfc_d   = '0;
                end
            endcase
        end
    end

    // Outputs registered from the next state so they align with state_q
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt_q    <= 1'b0;
            start_q  <= 1'b0;
            active_q <= 1'b0;
        end else begin
            gnt_q    <= (state_d == ST_HOST);
            start_q  <= start_d;
            active_q <= (state_d == ST_REFRESH);
        end
    end

    assign arb.host_gnt     = gnt_q;
    assign arb.ref_start    = start_q;
    assign arb.ref_active   = active_q;
    assign arb.pending      = pending_q;
    assign arb.ref_overflow = overflow_q;

    a_gnt_refresh_excl: assert property (@(posedge clk) disable iff (reset)
        !(gnt_q && active_q));

endmodule

// File: tb/tb_sdram_refresh_arbiter.sv
// Randomised and directed bench for sdram_refresh_arbiter against an
// ownership-level reference model.
module tb_sdram_refresh_arbiter;

    localparam int RI = 10;
    localparam int MP = 4;
    localparam int RC = 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    bit   chk_en = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    sdram_refresh_arbiter_if bus ();

    sdram_refresh_arbiter #(
        .REFRESH_INTERVAL (RI),
        .MAX_PENDING      (MP),
        .REF_CYCLES       (RC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .arb   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    endtask

    task automatic note_timeout(input string name, input int waited);
        n_checks++;
        $display("FAIL %s timed out after %0d clocks t=%0t", name, waited, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: who owns the SDRAM and how much refresh is owed.
    int m_since;            // clocks since init modulo the interval
    int m_pend;
    bit m_ovf;
    int m_refresh_left;     // clocks of refresh still to run
    bit m_host_owns;
    bit m_host_spent;       // host finished, waiting for its request to drop
    bit m_start;
    bit m_gnt;
    bit m_active;

    int  s_since, s_pend, s_left;
    bit  s_ovf, s_owns, s_spent, s_start, s_tick;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_since <= 0; m_pend <= 0; m_ovf <= 1'b0; m_refresh_left <= 0;
            m_host_owns <= 1'b0; m_host_spent <= 1'b0;
            m_start <= 1'b0; m_gnt <= 1'b0; m_active <= 1'b0;
        end else begin
            s_since = m_since; s_pend = m_pend; s_ovf = m_ovf;
            s_left = m_refresh_left; s_owns = m_host_owns; s_spent = m_host_spent;
            s_start = 1'b0;
            if (!bus.init_done) begin
                s_since = 0; s_pend = 0; s_left = 0; s_owns = 1'b0; s_spent = 1'b0;
            end else begin
                s_tick  = (m_since == RI - 1);
                s_since = (m_since + 1) % RI;
                if (s_tick && !m_start) begin
                    if (m_pend == MP) s_ovf = 1'b1;
                    else              s_pend = m_pend + 1;
                end else if (!s_tick && m_start) begin
                    s_pend = m_pend - 1;
                end
                if (m_refresh_left > 0) begin
                    s_left = m_refresh_left - 1;
                end else if (m_host_owns) begin
                    if (bus.host_done) begin
                        s_owns = 1'b0; s_spent = 1'b1;
                    end else if (!bus.host_req) begin
                        s_owns = 1'b0;
                    end
                end else if (m_host_spent) begin
                    if (!bus.host_req) s_spent = 1'b0;
                end else if (m_pend == MP || (!bus.host_req && m_pend > 0)) begin
                    s_left = RC; s_start = 1'b1;
                end else if (bus.host_req) begin
                    s_owns = 1'b1;
                end
            end
            m_since <= s_since; m_pend <= s_pend; m_ovf <= s_ovf;
            m_refresh_left <= s_left; m_host_owns <= s_owns; m_host_spent <= s_spent;
            m_start <= s_start; m_gnt <= s_owns; m_active <= (s_left > 0);
        end
    end

    // Cycle compare, away from the rising edge
    always @(negedge clk) begin
        if (chk_en && !reset) begin
            chk("host_gnt",     int'(bus.host_gnt),     int'(m_gnt));
            chk("ref_start",    int'(bus.ref_start),    int'(m_start));
            chk("ref_active",   int'(bus.ref_active),   int'(m_active));
            chk("pending",      int'(bus.pending),      m_pend);
            chk("ref_overflow", int'(bus.ref_overflow), int'(m_ovf));
            chk("gnt_active_excl", int'(bus.host_gnt & bus.ref_active), 0);
        end
    end

    // Align to a timer tick: returns right after a tick-driven refresh ends
    task automatic sync_phase();
        int b;
        b = 0;
        while (!(bus.pending == 4'd0 && !bus.ref_active && !bus.ref_start && !bus.host_gnt)
               && b < 200) begin step(); b++; end
        if (b >= 200) note_timeout("sync_idle", b);
        b = 0;
        while (!bus.ref_start && b < 40) begin step(); b++; end
        if (b >= 40) note_timeout("sync_start", b);
        b = 0;
        while (bus.ref_active && b < 40) begin step(); b++; end
        if (b >= 40) note_timeout("sync_end", b);
    endtask

    int n, cnt, bad, gap, last_start, min_gap, s_idx, g_idx, r;

    initial begin
        bus.init_done = 1'b0;
        bus.host_req  = 1'b0;
        bus.host_done = 1'b0;
        repeat (3) step();
        chk("rst_host_gnt",   int'(bus.host_gnt),     0);
        chk("rst_ref_start",  int'(bus.ref_start),    0);
        chk("rst_ref_active", int'(bus.ref_active),   0);
        chk("rst_pending",    int'(bus.pending),      0);
        chk("rst_overflow",   int'(bus.ref_overflow), 0);
        reset = 1'b0;
        chk_en = 1'b1;

        // init_done low: nothing accrues or issues
        bad = 0;
        repeat (50) begin
            step();
            if (bus.ref_start || bus.pending != 4'd0 || bus.host_gnt) bad++;
        end
        chk("init_hold_quiet", bad, 0);

        bus.init_done = 1'b1;
        n = 0;
        while (!bus.ref_start && n < 40) begin step(); n++; end
        chk("first_ref_latency", n, 11);
        cnt = 0;
        while (bus.ref_active && cnt < 20) begin cnt++; step(); end
        chk("ref_active_len", cnt, 3);
        chk("pending_after_first", int'(bus.pending), 0);

        // Host grant, done, no regrant while request held
        bus.host_req = 1'b1;
        step();
        chk("grant_latency", int'(bus.host_gnt), 1);
        repeat (4) step();
        bus.host_done = 1'b1;
        step();
        bus.host_done = 1'b0;
        chk("gnt_drop_after_done", int'(bus.host_gnt), 0);
        bad = 0;
        repeat (4) begin step(); if (bus.host_gnt) bad++; end
        chk("no_regrant", bad, 0);
        bus.host_req = 1'b0;

        // Deferral: debt accrues under a long host cycle, then drains
        sync_phase();
        bus.host_req = 1'b1;
        step();
        chk("defer_grant", int'(bus.host_gnt), 1);
        bad = 0;
        repeat (30) begin step(); if (bus.ref_start) bad++; end
        chk("no_ref_in_host", bad, 0);
        chk("defer_pending", int'(bus.pending), 3);
        bus.host_done = 1'b1;
        step();
        bus.host_done = 1'b0;
        bus.host_req  = 1'b0;
        min_gap = 1000; last_start = -1; n = 0;
        while (!(bus.pending == 4'd0 && !bus.ref_active) && n < 150) begin
            step(); n++;
            if (bus.ref_start) begin
                if (last_start >= 0) begin
                    gap = n - last_start;
                    if (gap < min_gap) min_gap = gap;
                end
                last_start = n;
            end
        end
        if (n >= 150) note_timeout("drain", n);
        chk("drain_min_gap", min_gap, 4);

        // Urgent debt delays a fresh host request by a full refresh
        sync_phase();
        bus.host_req = 1'b1;
        step();
        repeat (34) step();
        bus.host_done = 1'b1;
        step();
        bus.host_done = 1'b0;
        bus.host_req  = 1'b0;
        chk("urgent_pending_full", int'(bus.pending), 4);
        step();
        bus.host_req = 1'b1;
        s_idx = 0; g_idx = 0; n = 0;
        while (g_idx == 0 && n < 30) begin
            step(); n++;
            if (bus.ref_start && s_idx == 0) s_idx = n;
            if (bus.host_gnt) g_idx = n;
            if (n == 2) chk("urgent_pending_after", int'(bus.pending), 3);
        end
        chk("urgent_start_idx", s_idx, 1);
        chk("urgent_gnt_idx", g_idx, 5);
        bus.host_done = 1'b1;
        step();
        bus.host_done = 1'b0;
        bus.host_req  = 1'b0;

        // Overflow and a tick coinciding with ref_start
        sync_phase();
        bus.host_req = 1'b1;
        step();
        repeat (61) step();
        chk("sat_pending", int'(bus.pending), 4);
        chk("overflow_set", int'(bus.ref_overflow), 1);
        bus.host_done = 1'b1;
        step();
        bus.host_done = 1'b0;
        bus.host_req  = 1'b0;
        step();
        step();
        chk("aligned_start", int'(bus.ref_start), 1);
        step();
        chk("tick_and_start_pending", int'(bus.pending), 4);
        chk("overflow_sticky", int'(bus.ref_overflow), 1);

        // Aborted host cycle
        sync_phase();
        bus.host_req = 1'b1;
        step();
        step();
        step();
        bus.host_req = 1'b0;
        step();
        chk("abort_gnt_low", int'(bus.host_gnt), 0);

        // Asynchronous reset in the middle of a refresh
        n = 0;
        while (!bus.ref_active && n < 60) begin step(); n++; end
        if (n >= 60) note_timeout("wait_refresh", n);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_active",  int'(bus.ref_active),   0);
        chk("async_rst_pending", int'(bus.pending),      0);
        chk("async_rst_gnt",     int'(bus.host_gnt),     0);
        chk("async_rst_ovf",     int'(bus.ref_overflow), 0);
        step();
        reset = 1'b0;

        // Randomised traffic, init drops and one more reset
        for (int c = 0; c < 3000; c++) begin
            bus.host_done = 1'b0;
            if (bus.host_req) begin
                r = int'($urandom_range(0, 99));
                if (r < 8)       bus.host_done = 1'b1;
                else if (r < 12) bus.host_req  = 1'b0;
            end else if ($urandom_range(0, 99) < 25) begin
                bus.host_req = 1'b1;
            end
            if (bus.init_done && $urandom_range(0, 999) < 3) bus.init_done = 1'b0;
            else if (!bus.init_done && $urandom_range(0, 99) < 10) bus.init_done = 1'b1;
            if (c == 1500) begin
                #2;
                reset = 1'b1;
                step();
                reset = 1'b0;
            end
            step();
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sdram_refresh_arbiter.md
Name: sdram_refresh_arbiter

Overview:
Sequences access to the single SDRAM device between Zorro II host RAM cycles and periodic auto-refresh. A free-running interval timer accrues owed refreshes into a pending counter. Refreshes are issued opportunistically when the bus is idle, and forced ahead of host cycles once the debt reaches its limit. Sits between the Z2 bus state tracking and the SDRAM command sequencer; the sequencer issues AUTO REFRESH on ref_start and RAM accesses only while host_gnt is high.

Parameters:
REFRESH_INTERVAL, 390, clocks between refresh ticks (7.8 us at 50 MHz); must be ≥2.
MAX_PENDING, 8, refresh debt limit; 1..15.
REF_CYCLES, 4, clocks the arbiter stays in REFRESH (tRFC plus margin); ≥1.

Ports:
clk  input  1  MEMCLK domain clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
init_done  input  1  SDRAM init sequence complete; arbiter inert while low
host_req  input  1  synchronised Z2 RAM access request, level, held for the bus cycle
host_done  input  1  one-clock pulse, sequencer finished host access (DTACK issued)
host_gnt  output  1  host owns SDRAM, registered
ref_start  output  1  one-clock pulse: issue AUTO REFRESH now, registered
ref_active  output  1  high throughout REFRESH state
pending  output  4  owed refresh count, 0..MAX_PENDING
ref_overflow  output  1  sticky: a tick arrived while pending == MAX_PENDING

Behaviour:
- Reset values: host_gnt=0, ref_start=0, ref_active=0, pending=0, ref_overflow=0, state=IDLE, timer=0, rfc counter=0. Reset assertion mid-cycle aborts any grant or refresh immediately, asynchronously.
- init_done low: timer held at 0; pending held at 0; state forced IDLE; no grants.
- Timer: counts 0..REFRESH_INTERVAL-1 and wraps. tick = (timer == REFRESH_INTERVAL-1).
- Pending update per clock:
  - tick alone: +1, saturating at MAX_PENDING.
  - ref_start alone: -1.
  - Both in the same clock: unchanged.
  - tick with pending == MAX_PENDING and no ref_start: pending stays; ref_overflow set; ref_overflow cleared only by reset.
- States: IDLE, HOST, HOST_END, REFRESH.
- IDLE, evaluated in priority order:
  1. pending == MAX_PENDING → REFRESH (urgent; host waits).
  2. host_req → HOST.
  3. pending > 0 → REFRESH.
  4. otherwise stay.
- HOST:
  - host_gnt high.
  - host_done → HOST_END.
  - host_req low without host_done (aborted cycle) → IDLE.
  - host_done takes precedence if both occur.
  - Urgent refresh never preempts HOST.
- HOST_END:
  - host_gnt low.
  - Wait for host_req low, then → IDLE.
  - Guarantees one grant per bus cycle.
- REFRESH:
  - ref_active high.
  - ref_start high only in the first clock of the state.
  - rfc counter counts REF_CYCLES clocks, then → IDLE.
  - Back-to-back refreshes drain debt when no host request is waiting; between them there is at least one IDLE clock.
- Latency:
  - host_req seen in IDLE (non-urgent) → host_gnt high on the next edge.
  - Worst case with urgent debt: host_gnt delayed by REF_CYCLES+1 clocks.
- host_gnt and ref_active are mutually exclusive at all times.
- host_done outside HOST is ignored.

Test Plan:
Bench parameters: REFRESH_INTERVAL=10, MAX_PENDING=4, REF_CYCLES=3.
1. Reset and init: hold reset, then init_done=0 for 50 clocks → pending=0, no ref_start. Raise init_done → first ref_start 11 clocks later, ref_active high exactly 3 clocks, pending back to 0.
2. Host grant: idle with pending=0; raise host_req → host_gnt=1 next clock. Pulse host_done after 5 clocks → host_gnt=0 next clock. Keep host_req high 4 more clocks → no regrant. Drop host_req → IDLE.
3. Deferral: hold a host cycle for 35 clocks → pending reaches 3, no ref_start during HOST. After host_done and host_req low → three ref_start pulses, each ≥4 clocks apart, pending 3→0.
4. Urgent priority: let pending reach 4 inside a long host cycle. End it, then re-request immediately → ref_start precedes host_gnt, pending=3, host_gnt follows after 4 clocks.
5. Overflow and simultaneity: hold HOST for 60 clocks → pending saturates at 4, ref_overflow=1 and stays 1. Align a tick with ref_start → pending unchanged that clock.
6. Abort and reset: drop host_req mid-HOST without host_done → host_gnt=0 next clock, state IDLE. Assert reset during REFRESH → ref_active=0 and pending=0 immediately.
